order_gen: RTL

ORDER_GEN -- requirements
Module: order_gen

---
 rtl/order_pkg.sv | 52 +++++
 rtl/order_fifo.sv | 52 +++++
 rtl/order_gen.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/order_pkg.sv
// Shared types for the order generator: order encodings, FSM states and the
// per-order attribute record carried through the order FIFO.
package order_pkg;

  typedef enum logic {
    ORD_NEW    = 1'b0,
    ORD_CANCEL = 1'b1
  } order_type_e;

  typedef enum logic {
    SIDE_BUY  = 1'b0,
    SIDE_SELL = 1'b1
  } order_side_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CXL_BID = 3'd1,
    ST_NEW_BID = 3'd2,
    ST_CXL_ASK = 3'd3,
    ST_NEW_ASK = 3'd4
  } state_e;

  // Instrument-width-independent order attributes; stock id and price travel
  // alongside because their widths are set by the top-level parameters.
  typedef struct packed {
    order_type_e otype;
    order_side_e side;
    logic [15:0] qty;
  } order_t;

  // First state after 'cur' in the fixed CXL_BID..NEW_ASK sequence whose
  // need bit is set; IDLE when none remain.
  // need[0]=CXL_BID, need[1]=NEW_BID, need[2]=CXL_ASK, need[3]=NEW_ASK.
  function automatic state_e next_after(state_e cur, logic [3:0] need);
    logic [3:0] mask;
    logic [3:0] pend;
    unique case (cur)
      ST_IDLE:    mask = 4'b1111;
      ST_CXL_BID: mask = 4'b1110;
      ST_NEW_BID: mask = 4'b1100;
      ST_CXL_ASK: mask = 4'b1000;
      default:    mask = 4'b0000;
    endcase
    pend = need & mask;
    if (pend[0])      next_after = ST_CXL_BID;
    else if (pend[1]) next_after = ST_NEW_BID;
    else if (pend[2]) next_after = ST_CXL_ASK;
    else if (pend[3]) next_after = ST_NEW_ASK;
    else              next_after = ST_IDLE;
  endfunction

endpackage

// File: rtl/order_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is always visible
// on o_data while not empty. Push on a full FIFO is accepted when a pop
// happens in the same cycle.
module order_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  // Status flags and accepted push/pop qualifiers.
  always_comb begin
    o_empty = (wr_ptr == rd_ptr);
    o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop  = i_pop && !o_empty;
    do_push = i_push && (!o_full || do_pop);
    o_data  = mem[rd_ptr[AW-1:0]];
  end

  // Pointer registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage array; contents are don't-care while the pointers say empty.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/order_gen.sv
// Order generator: turns per-instrument desired bid/ask quotes into
// CANCEL/NEW orders against a quote table, queued in an FWFT order FIFO.
module order_gen
  import order_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_STOCKS = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] ORDER_QTY  = 16'd100
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [$clog2(NUM_STOCKS)-1:0] i_stock_id,
  input  logic [DATA_WIDTH-1:0]         i_buy_price,
  input  logic [DATA_WIDTH-1:0]         i_sell_price,
  input  logic                          i_data_valid,
  input  logic                          i_order_ready,
  output logic                          o_order_valid,
  output logic                          o_order_type,
  output logic                          o_order_side,
  output logic [$clog2(NUM_STOCKS)-1:0] o_order_stock_id,
  output logic [DATA_WIDTH-1:0]         o_order_price,
  output logic [15:0]                   o_order_qty,
  output logic [15:0]                   o_drop_count
);

  localparam int unsigned ID_W  = $clog2(NUM_STOCKS);
  localparam int unsigned PAY_W = $bits(order_t) + ID_W + DATA_WIDTH;

  state_e state;
  state_e state_d;

  // Skid register: one pending quote.
  logic                  skid_valid;
  logic [ID_W-1:0]       skid_id;
  logic [DATA_WIDTH-1:0] skid_bid;
  logic [DATA_WIDTH-1:0] skid_ask;

  // Working quote being processed by the FSM.
  logic [ID_W-1:0]       w_id;
  logic [DATA_WIDTH-1:0] w_bid;
  logic [DATA_WIDTH-1:0] w_ask;

  // Quote table.
  logic [DATA_WIDTH-1:0] bid_price [NUM_STOCKS];
  logic [DATA_WIDTH-1:0] ask_price [NUM_STOCKS];
  logic [NUM_STOCKS-1:0] bid_active;
  logic [NUM_STOCKS-1:0] ask_active;

  logic                  bypass;
  logic                  consume;
  logic                  start;
  logic                  skid_load;
  logic                  drop;
  logic [ID_W-1:0]       src_id;
  logic [DATA_WIDTH-1:0] src_bid;
  logic [DATA_WIDTH-1:0] src_ask;
  logic [DATA_WIDTH-1:0] tbl_bid;
  logic [DATA_WIDTH-1:0] tbl_ask;
  logic                  tbl_bid_act;
  logic                  tbl_ask_act;
  logic [3:0]            need;
  logic                  cur_need;

  logic                  push;
  logic                  pop;
  logic                  space;
  logic                  fifo_empty;
  logic                  fifo_full;
  order_t                ord_hdr;
  logic [DATA_WIDTH-1:0] ord_price;
  logic [PAY_W-1:0]      fifo_wdata;
  logic [PAY_W-1:0]      fifo_rdata;
  order_t                head_hdr;
  logic [ID_W-1:0]       head_id;
  logic [DATA_WIDTH-1:0] head_price;

  // Quote intake: an idle FSM with an empty skid takes the strobed quote
  // directly so the first order can appear two cycles after the strobe;
  // otherwise the strobe lands in the skid, overwriting any unconsumed quote.
  always_comb begin
    bypass    = (state == ST_IDLE) && !skid_valid && i_data_valid;
    consume   = (state == ST_IDLE) && skid_valid;
    start     = bypass || consume;
    skid_load = i_data_valid && !bypass;
    drop      = skid_load && skid_valid && !consume;
    if (state != ST_IDLE) begin
      src_id  = w_id;
      src_bid = w_bid;
      src_ask = w_ask;
    end else if (skid_valid) begin
      src_id  = skid_id;
      src_bid = skid_bid;
      src_ask = skid_ask;
    end else begin
      src_id  = i_stock_id;
      src_bid = i_buy_price;
      src_ask = i_sell_price;
    end
  end

  // Table lookup and per-step order requirements. Needs are derived from the
  // table as it stood before this quote's updates; ask entries are untouched
  // by the bid steps, so the flags stay valid through the whole sequence.
  always_comb begin
    tbl_bid     = bid_price[src_id];
    tbl_ask     = ask_price[src_id];
    tbl_bid_act = bid_active[src_id];
    tbl_ask_act = ask_active[src_id];
    need[0]     = tbl_bid_act && (src_bid != tbl_bid);
    need[1]     = (src_bid != '0) && (!tbl_bid_act || (src_bid != tbl_bid));
    need[2]     = tbl_ask_act && (src_ask != tbl_ask);
    need[3]     = (src_ask != '0) && (!tbl_ask_act || (src_ask != tbl_ask));
  end

  // Next-state and FIFO write generation. States with nothing to send are
  // passed over in the transition itself, so only writing states take cycles.
  always_comb begin
    state_d   = state;
    push      = 1'b0;
    cur_need  = 1'b0;
    ord_hdr   = '{otype: ORD_NEW, side: SIDE_BUY, qty: ORDER_QTY};
    ord_price = w_bid;
    unique case (state)
      ST_CXL_BID: begin
        cur_need  = need[0];
        ord_hdr   = '{otype: ORD_CANCEL, side: SIDE_BUY, qty: 16'd0};
        ord_price = tbl_bid;
      end
      ST_NEW_BID: begin
        cur_need  = need[1];
        ord_hdr   = '{otype: ORD_NEW, side: SIDE_BUY, qty: ORDER_QTY};
        ord_price = w_bid;
      end
      ST_CXL_ASK: begin
        cur_need  = need[2];
        ord_hdr   = '{otype: ORD_CANCEL, side: SIDE_SELL, qty: 16'd0};
        ord_price = tbl_ask;
      end
      ST_NEW_ASK: begin
        cur_need  = need[3];
        ord_hdr   = '{otype: ORD_NEW, side: SIDE_SELL, qty: ORDER_QTY};
        ord_price = w_ask;
      end
      default: ;
    endcase
    if (state == ST_IDLE) begin
      if (start) state_d = next_after(ST_IDLE, need);
    end else if (!cur_need) begin
      state_d = next_after(state, need);
    end else if (space) begin
      push    = 1'b1;
      state_d = next_after(state, need);
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_IDLE;
    else            state <= state_d;
  end

  // Skid register, working quote and saturating drop counter.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      skid_valid   <= 1'b0;
      skid_id      <= '0;
      skid_bid     <= '0;
      skid_ask     <= '0;
      w_id         <= '0;
      w_bid        <= '0;
      w_ask        <= '0;
      o_drop_count <= '0;
    end else begin
      if (skid_load) begin
        skid_valid <= 1'b1;
        skid_id    <= i_stock_id;
        skid_bid   <= i_buy_price;
        skid_ask   <= i_sell_price;
      end else if (consume) begin
        skid_valid <= 1'b0;
      end
      if (start) begin
        w_id  <= src_id;
        w_bid <= src_bid;
        w_ask <= src_ask;
      end
      if (drop && (o_drop_count != '1)) o_drop_count <= o_drop_count + 16'd1;
    end
  end

  // Quote table updates, applied only on the cycle the order is written.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bid_active <= '0;
      ask_active <= '0;
      for (int unsigned i = 0; i < NUM_STOCKS; i++) begin
        bid_price[i] <= '0;
        ask_price[i] <= '0;
      end
    end else if (push) begin
      unique case (state)
        ST_CXL_BID: bid_active[w_id] <= 1'b0;
        ST_NEW_BID: begin
          bid_active[w_id] <= 1'b1;
          bid_price[w_id]  <= w_bid;
        end
        ST_CXL_ASK: ask_active[w_id] <= 1'b0;
        ST_NEW_ASK: begin
          ask_active[w_id] <= 1'b1;
          ask_price[w_id]  <= w_ask;
        end
        default: ;
      endcase
    end
  end

  // FIFO handshake: a write may proceed into a full FIFO when the head leaves
  // in the same cycle.
  always_comb begin
    pop        = !fifo_empty && i_order_ready;
    space      = !fifo_full || pop;
    fifo_wdata = {ord_hdr, w_id, ord_price};
  end

  order_fifo #(
    .WIDTH (PAY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_push      (push),
    .i_push_data (fifo_wdata),
    .i_pop       (pop),
    .o_data      (fifo_rdata),
    .o_empty     (fifo_empty),
    .o_full      (fifo_full)
  );

  // Head-of-queue outputs, forced to zero while no order is presented.
  always_comb begin
    {head_hdr, head_id, head_price} = fifo_rdata;
    o_order_valid    = !fifo_empty;
    o_order_type     = 1'b0;
    o_order_side     = 1'b0;
    o_order_stock_id = '0;
    o_order_price    = '0;
    o_order_qty      = '0;
    if (o_order_valid) begin
      o_order_type     = head_hdr.otype;
      o_order_side     = head_hdr.side;
      o_order_stock_id = head_id;
      o_order_price    = head_price;
      o_order_qty      = head_hdr.qty;
    end
  end

endmodule
